// File: rtl/shift_cmd_if.sv
// Command and result handshake bundle for the shift command sequencer.
// The master side offers commands and consumes results; the slave side is the sequencer.
interface shift_cmd_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_data;
  logic [1:0] cmd_amt;
  logic       cmd_dir;
  logic [2:0] cmd_repeat;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;

  modport master (
    output cmd_valid, cmd_data, cmd_amt, cmd_dir, cmd_repeat, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_amt, cmd_dir, cmd_repeat, res_ready,
    output cmd_ready, res_valid, res_data
  );
endinterface

// File: rtl/shift_cmd_sequencer.sv
// Queues shift commands and steps an external combinational barrel shifter,
// one pass per cycle, returning the final word over a valid/ready result port.
module shift_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  shift_cmd_if.slave               bus,
  output logic [3:0]               shf_data,
  output logic [1:0]               shf_amt,
  output logic                     shf_dir,
  input  logic [3:0]               shf_result,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] amt;
    logic       dir;
    logic [2:0] rep;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  state_t        state;
  logic [2:0]    remaining;
  logic          res_valid_q;
  logic [3:0]    res_data_q;

  // Ready looks at occupancy only, so a pop on a full cycle never admits a push.
  assign bus.cmd_ready = (count < FULL);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign pop           = (state == IDLE) && (count != '0);
  assign head          = mem[rd_ptr];
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign fifo_level    = count;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{data: bus.cmd_data, amt: bus.cmd_amt,
                               dir: bus.cmd_dir, rep: bus.cmd_repeat};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shf_data    <= '0;
      shf_amt     <= '0;
      shf_dir     <= 1'b0;
      remaining   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          shf_data  <= head.data;
          shf_amt   <= head.amt;
          shf_dir   <= head.dir;
          remaining <= head.rep;
          state     <= SHIFT;
        end
        // Shifter output feeds back into its own input for the next pass.
        SHIFT: begin
          shf_data <= shf_result;
          if (remaining == '0) begin
            res_data_q  <= shf_result;
            res_valid_q <= 1'b1;
            state       <= HOLD;
          end else begin
            remaining <= remaining - 3'd1;
          end
        end
        HOLD: if (bus.res_ready) begin
          res_valid_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Directed bench for shift_cmd_sequencer with an ideal rotate standing in for the shifter.
module tb_shift_cmd_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] shf_data, shf_result;
  logic [1:0] shf_amt;
  logic       shf_dir;
  logic [2:0] fifo_level;
  logic       busy;
  int         errors = 0;
  int         checks = 0;

  shift_cmd_if bif ();

  shift_cmd_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif.slave),
    .shf_data(shf_data), .shf_amt(shf_amt), .shf_dir(shf_dir),
    .shf_result(shf_result), .fifo_level(fifo_level), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rot(input logic [3:0] d, input logic [1:0] a, input logic r);
    logic [7:0] w;
    w = {d, d};
    if (r) rot = 4'(w >> a);
    else   rot = 4'((w << a) >> 4);
  endfunction

  assign shf_result = rot(shf_data, shf_amt, shf_dir);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] d, input logic [1:0] a, input logic r, input logic [2:0] rp);
    bif.cmd_valid  = 1'b1;
    bif.cmd_data   = d;
    bif.cmd_amt    = a;
    bif.cmd_dir    = r;
    bif.cmd_repeat = rp;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (bif.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", bif.res_valid); end
    checks++; if (bif.res_data !== 4'b0000) begin errors++; $display("FAIL reset_res_data got %b want 0000", bif.res_data); end
    checks++; if (bif.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", bif.cmd_ready); end
    checks++; if ({shf_data, shf_amt, shf_dir} !== 7'd0) begin errors++; $display("FAIL reset_shf got %b want 0", {shf_data, shf_amt, shf_dir}); end
    checks++; if (fifo_level !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_level_busy got %0d/%b want 0/0", fifo_level, busy); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    drive(4'b1001, 2'd1, 1'b0, 3'd0);
    tick();
    bif.cmd_valid = 1'b0;
    checks++; if (fifo_level !== 3'd1 || busy !== 1'b0) begin errors++; $display("FAIL single_e0 level/busy got %0d/%b want 1/0", fifo_level, busy); end
    tick();
    checks++; if (shf_data !== 4'b1001 || shf_amt !== 2'd1) begin errors++; $display("FAIL single_e1 shf got %b/%0d want 1001/1", shf_data, shf_amt); end
    checks++; if (fifo_level !== 3'd0 || busy !== 1'b1 || bif.res_valid !== 1'b0) begin errors++; $display("FAIL single_e1 state got lvl%0d busy%b rv%b want 0/1/0", fifo_level, busy, bif.res_valid); end
    tick();
    checks++; if (bif.res_valid !== 1'b1 || bif.res_data !== 4'b0011) begin errors++; $display("FAIL single_result got rv%b %b want 1 0011", bif.res_valid, bif.res_data); end
    bif.res_ready = 1'b1;
    tick();
    bif.res_ready = 1'b0;
    checks++; if (bif.res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done got rv%b busy%b want 0/0", bif.res_valid, busy); end
  endtask

  task automatic test_multi();
    logic [3:0] seq [3];
    seq = '{4'b0001, 4'b0010, 4'b0100};
    drive(4'b0001, 2'd1, 1'b0, 3'd2);
    tick();
    bif.cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (shf_data !== seq[i] || bif.res_valid !== 1'b0) begin errors++; $display("FAIL multi_pass%0d got %b rv%b want %b rv0", i, shf_data, bif.res_valid, seq[i]); end
    end
    tick();
    checks++; if (bif.res_valid !== 1'b1 || bif.res_data !== 4'b1000) begin errors++; $display("FAIL multi_result got rv%b %b want 1 1000", bif.res_valid, bif.res_data); end
    bif.res_ready = 1'b1;
    tick();
    bif.res_ready = 1'b0;
  endtask

  task automatic test_right_shift();
    drive(4'b1000, 2'd3, 1'b1, 3'd1);
    tick();
    bif.cmd_valid = 1'b0;
    tick();
    checks++; if (shf_data !== 4'b1000 || shf_dir !== 1'b1) begin errors++; $display("FAIL right_load got %b dir%b want 1000 dir1", shf_data, shf_dir); end
    tick();
    checks++; if (shf_data !== 4'b0001) begin errors++; $display("FAIL right_pass1 got %b want 0001", shf_data); end
    tick();
    checks++; if (bif.res_valid !== 1'b1 || bif.res_data !== 4'b0010) begin errors++; $display("FAIL right_result got rv%b %b want 1 0010", bif.res_valid, bif.res_data); end
    bif.res_ready = 1'b1;
    tick();
    bif.res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    drive(4'b0110, 2'd2, 1'b0, 3'd0);
    tick();
    drive(4'b0011, 2'd1, 1'b0, 3'd0);
    tick();
    bif.cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (bif.res_valid !== 1'b1 || bif.res_data !== 4'b1001 || shf_data !== 4'b1001 || shf_amt !== 2'd2 || fifo_level !== 3'd1)
        begin errors++; $display("FAIL bp_hold%0d got rv%b res%b shf%b amt%0d lvl%0d want 1 1001 1001 2 1", i, bif.res_valid, bif.res_data, shf_data, shf_amt, fifo_level); end
      tick();
    end
    bif.res_ready = 1'b1;
    tick();
    bif.res_ready = 1'b0;
    checks++; if (bif.res_valid !== 1'b0 || busy !== 1'b0 || fifo_level !== 3'd1) begin errors++; $display("FAIL bp_handshake got rv%b busy%b lvl%0d want 0 0 1", bif.res_valid, busy, fifo_level); end
    tick();
    checks++; if (busy !== 1'b1 || fifo_level !== 3'd0 || shf_data !== 4'b0011) begin errors++; $display("FAIL bp_next_pop got busy%b lvl%0d shf%b want 1 0 0011", busy, fifo_level, shf_data); end
    tick();
    checks++; if (bif.res_valid !== 1'b1 || bif.res_data !== 4'b0110) begin errors++; $display("FAIL bp_next_result got rv%b %b want 1 0110", bif.res_valid, bif.res_data); end
    bif.res_ready = 1'b1;
    tick();
    bif.res_ready = 1'b0;
  endtask

  task automatic test_full_fifo();
    logic [3:0] cd [6];
    logic [1:0] ca [6];
    logic       cr [6];
    logic [2:0] cp [6];
    logic [3:0] exp_res [6];
    int idx, got;
    logic acc;
    cd = '{4'b0001, 4'b0011, 4'b1000, 4'b0101, 4'b1110, 4'b1011};
    ca = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd3, 2'd1};
    cr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    cp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0};
    exp_res = '{4'b0010, 4'b1100, 4'b0001, 4'b0101, 4'b0111, 4'b1101};
    bif.res_ready = 1'b0;
    idx = 0;
    drive(cd[0], ca[0], cr[0], cp[0]);
    for (int c = 0; c < 10; c++) begin
      acc = bif.cmd_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 6) drive(cd[idx], ca[idx], cr[idx], cp[idx]);
      end
    end
    checks++; if (idx !== 5) begin errors++; $display("FAIL full_accepted got %0d want 5", idx); end
    checks++; if (fifo_level !== 3'd4 || bif.cmd_ready !== 1'b0) begin errors++; $display("FAIL full_level got lvl%0d rdy%b want 4 0", fifo_level, bif.cmd_ready); end
    checks++; if (bif.res_valid !== 1'b1 || bif.res_data !== 4'b0010) begin errors++; $display("FAIL full_head_hold got rv%b %b want 1 0010", bif.res_valid, bif.res_data); end
    bif.res_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 100 && got < 6; c++) begin
      acc = bif.cmd_ready && bif.cmd_valid;
      if (bif.res_valid) begin
        checks++; if (bif.res_data !== exp_res[got]) begin errors++; $display("FAIL full_result%0d got %b want %b", got, bif.res_data, exp_res[got]); end
        got++;
      end
      tick();
      if (acc) begin
        idx++;
        bif.cmd_valid = 1'b0;
      end
    end
    bif.res_ready = 1'b0;
    bif.cmd_valid = 1'b0;
    checks++; if (got !== 6 || idx !== 6) begin errors++; $display("FAIL full_drain got %0d results %0d accepts want 6 6", got, idx); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    drive(4'b0001, 2'd1, 1'b0, 3'd5);
    tick();
    drive(4'b1111, 2'd1, 1'b1, 3'd0);
    tick();
    bif.cmd_valid = 1'b0;
    tick();
    checks++; if (busy !== 1'b1 || fifo_level !== 3'd1) begin errors++; $display("FAIL rmid_pre got busy%b lvl%0d want 1 1", busy, fifo_level); end
    rst_n = 1'b0;
    #1;
    checks++; if (bif.res_valid !== 1'b0 || busy !== 1'b0 || fifo_level !== 3'd0 || bif.cmd_ready !== 1'b1)
      begin errors++; $display("FAIL rmid_ctrl got rv%b busy%b lvl%0d rdy%b want 0 0 0 1", bif.res_valid, busy, fifo_level, bif.cmd_ready); end
    checks++; if ({shf_data, shf_amt, shf_dir} !== 7'd0) begin errors++; $display("FAIL rmid_shf got %b want 0", {shf_data, shf_amt, shf_dir}); end
    tick(); tick();
    rst_n = 1'b1;
    bif.res_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bif.res_valid || busy) seen = 1'b1;
    end
    bif.res_ready = 1'b0;
    checks++; if (seen !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL rmid_dropped got activity%b lvl%0d want 0 0", seen, fifo_level); end
  endtask

  initial begin
    bif.cmd_valid  = 1'b0;
    bif.cmd_data   = '0;
    bif.cmd_amt    = '0;
    bif.cmd_dir    = 1'b0;
    bif.cmd_repeat = '0;
    bif.res_ready  = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_right_shift();
    test_backpressure();
    test_full_fifo();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
